// File: rtl/aes_core_arbiter_if.sv
// Requester, response and core-side signals of the shared AES core arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and core.
interface aes_core_arbiter_if;
    logic [1:0]   req_valid;
    logic [0:127] req0_data;
    logic [0:127] req1_data;
    logic [1:0]   req_accept;
    logic [1:0]   rsp_valid;
    logic [0:127] rsp_data;
    logic         rsp_err;
    logic [1:0]   rsp_ack;
    logic         core_ready;
    logic [0:127] core_data_in;
    logic         core_complete;
    logic [0:127] core_data_out;
    logic         busy;
    logic         timeout_flag;
    logic         clr_err;

    modport slave (
        input  req_valid, req0_data, req1_data, rsp_ack,
               core_complete, core_data_out, clr_err,
        output req_accept, rsp_valid, rsp_data, rsp_err,
               core_ready, core_data_in, busy, timeout_flag
    );

    modport master (
        output req_valid, req0_data, req1_data, rsp_ack,
               core_complete, core_data_out, clr_err,
        input  req_accept, rsp_valid, rsp_data, rsp_err,
               core_ready, core_data_in, busy, timeout_flag
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// Round-robin sharing of one aes_control core between the USB OUT path (req0)
// and the self-test path (req1), with a completion watchdog.
module aes_core_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    aes_core_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic         r_last_grant;
    logic         r_grant;
    logic [CNT_W-1:0] r_wdog;
    logic [0:127] r_core_data_in;
    logic [0:127] r_rsp_data;
    logic [1:0]   r_rsp_valid;
    logic         r_rsp_err;
    logic         r_busy;
    logic         r_timeout_flag;

    logic [1:0]   w_accept;
    logic         w_grant_idx;
    logic         w_done;
    logic         w_timeout;
    logic         w_ack;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = '0;
        w_grant_idx = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        w_ack       = 1'b0;

        // On a tie, the requester not served last wins.
        case (bus.req_valid)
            2'b01:   w_grant_idx = 1'b0;
            2'b10:   w_grant_idx = 1'b1;
            2'b11:   w_grant_idx = ~r_last_grant;
            default: w_grant_idx = 1'b0;
        endcase

        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) begin
                    w_accept[w_grant_idx] = 1'b1;
                    w_next                = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_complete) begin
                    w_done = 1'b1;
                    w_next = S_RESPOND;
                end else if (r_wdog == TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (bus.rsp_ack[r_grant]) begin
                    w_ack  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_last_grant   <= 1'b1;
            r_grant        <= 1'b0;
            r_wdog         <= '0;
            r_core_data_in <= '0;
            r_rsp_data     <= '0;
            r_rsp_valid    <= '0;
            r_rsp_err      <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            if (|w_accept) begin
                r_grant        <= w_grant_idx;
                r_core_data_in <= w_grant_idx ? bus.req1_data : bus.req0_data;
            end

            if (r_state == S_ISSUE) begin
                r_wdog <= '0;
            end else if (r_state == S_WAIT) begin
                r_wdog <= r_wdog + CNT_W'(1);
            end

            if (w_done) begin
                r_rsp_data <= bus.core_data_out;
                r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end

            r_rsp_valid <= (w_next == S_RESPOND) ? {r_grant, ~r_grant} : 2'b00;

            if (w_ack) begin
                r_last_grant <= r_grant;
            end

            // A timeout declared in the same cycle as clr_err still sets the flag.
            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (bus.clr_err) begin
                r_timeout_flag <= 1'b0;
            end

            r_busy <= (w_next != S_IDLE);
        end
    end

    assign bus.req_accept   = w_accept;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.core_ready   = (r_state == S_ISSUE);
    assign bus.core_data_in = r_core_data_in;
    assign bus.busy         = r_busy;
    assign bus.timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: a behavioural core model plus a round-robin
// reference, driven with directed and randomized requests.
`timescale 1ns/1ps
module tb_aes_core_arbiter;

    localparam int unsigned TMO = 64;

    localparam logic [0:127] P_SINGLE = 128'h61646a6163656e746163746976617465;
    localparam logic [0:127] C_SINGLE = 128'hb1e9645c3fc771108b4ce598d2896ee5;
    localparam logic [0:127] P_A      = 128'h616172647661726b616172647661726b;
    localparam logic [0:127] P_B      = 128'h626564736f7265736265646672616d65;
    localparam logic [0:127] C_B      = 128'h36b8bd11fb127be91568ba69c370cbe5;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    aes_core_arbiter_if bus ();

    aes_core_arbiter #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // core model state
    int           core_lat  = 10;
    bit           core_mute = 1'b0;
    bit           pend      = 1'b0;
    int           due       = 0;
    logic [0:127] pdata     = '0;
    int           ready_cnt = 0;
    int           ready_cyc = -1;

    // reference arbitration state: index of the requester served last
    logic m_last = 1'b1;

    // Known blocks map to their ciphertexts; anything else gets a fixed scramble.
    function automatic logic [0:127] core_fn(input logic [0:127] p);
        if (p == P_SINGLE) return C_SINGLE;
        if (p == P_B)      return C_B;
        return {p[64:127], p[0:63]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] rv, input logic last);
        if (rv == 2'b11) return last ? 2'b01 : 2'b10;
        return rv;
    endfunction

    // Advance to the next falling edge and run the core model for the new cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.core_complete = 1'b0;
        bus.core_data_out = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (bus.core_ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
            if (!core_mute) begin
                pend  = 1'b1;
                due   = cyc + core_lat;
                pdata = bus.core_data_in;
            end
        end
        if (pend && cyc == due) begin
            bus.core_complete = 1'b1;
            bus.core_data_out = core_fn(pdata);
            pend = 1'b0;
        end
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ack   = '0;
        bus.clr_err   = 1'b0;
        pend      = 1'b0;
        core_mute = 1'b0;
        tick();
        tick();
        n_rst  = 1'b1;
        m_last = 1'b1;
        tick();
    endtask

    // Waits for an accept, drops that request bit, then waits for rsp_valid (no ack).
    task automatic serve_one(output logic [1:0] acc, output int acc_cyc, output logic [1:0] rv,
                             output logic [0:127] rd, output logic re, output int v_cyc,
                             output int extra_acc);
        acc = '0; rv = '0; rd = '0; re = 1'b0; acc_cyc = -1; v_cyc = -1; extra_acc = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_accept !== 2'b00) begin
                acc = bus.req_accept;
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        if (acc == 2'b00) return;
        tick();
        bus.req_valid = bus.req_valid & ~acc;
        for (int i = 0; i < int'(TMO) + 40; i++) begin
            #1;
            if (bus.req_accept !== 2'b00) extra_acc++;
            if (bus.rsp_valid !== 2'b00) begin
                rv = bus.rsp_valid; rd = bus.rsp_data; re = bus.rsp_err; v_cyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic do_ack(input logic [1:0] a);
        bus.rsp_ack = a;
        tick();
        bus.rsp_ack = '0;
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        tick();
        #1;
        vectors++; if (bus.req_accept !== 2'b00) begin errors++; $display("FAIL reset_req_accept: got %b expected 00", bus.req_accept); end
        vectors++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
        vectors++; if (bus.rsp_data !== 128'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %h/%b expected 0/0", bus.rsp_data, bus.rsp_err); end
        vectors++; if (bus.core_ready !== 1'b0 || bus.core_data_in !== 128'h0) begin errors++; $display("FAIL reset_core: got %b/%h expected 0/0", bus.core_ready, bus.core_data_in); end
        vectors++; if (bus.busy !== 1'b0 || bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b tmo=%b expected 0/0", bus.busy, bus.timeout_flag); end
        n_rst = 1'b1;
        m_last = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [1:0] acc, rv; logic [0:127] rd; logic re; int ac, vc, ex, r0;
        apply_reset();
        core_lat = 10;
        bus.req0_data = P_SINGLE;
        bus.req_valid = 2'b01;
        r0 = ready_cnt;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (acc !== 2'b01) begin errors++; $display("FAIL single_accept: got %b expected 01", acc); end
        vectors++; if (ex !== 0) begin errors++; $display("FAIL single_accept_width: got %0d extra accept cycles expected 0", ex); end
        vectors++; if (ready_cnt - r0 !== 1 || ready_cyc !== ac + 1) begin errors++; $display("FAIL single_ready: got %0d pulses at %0d expected 1 at %0d", ready_cnt - r0, ready_cyc, ac + 1); end
        vectors++; if (vc !== ac + 12) begin errors++; $display("FAIL single_latency: got cycle %0d expected %0d", vc, ac + 12); end
        vectors++; if (rv !== 2'b01 || rd !== C_SINGLE || re !== 1'b0) begin errors++; $display("FAIL single_rsp: got %b %h %b expected 01 %h 0", rv, rd, re, C_SINGLE); end
        vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
        do_ack(2'b01);
        m_last = 1'b0;
        vectors++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_ack: got valid=%b busy=%b expected 00/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_simultaneous();
        logic [1:0] acc, rv, ea; logic [0:127] rd; logic re; int ac, vc, ex;
        apply_reset();
        core_lat = 5;
        for (int r = 0; r < 2; r++) begin
            bus.req0_data = P_A;
            bus.req1_data = P_B;
            bus.req_valid = 2'b11;
            for (int k = 0; k < 2; k++) begin
                ea = ref_grant(bus.req_valid, m_last);
                serve_one(acc, ac, rv, rd, re, vc, ex);
                vectors++; if (acc !== ea || rv !== ea) begin errors++; $display("FAIL simul_grant: got acc=%b valid=%b expected %b", acc, rv, ea); end
                vectors++; if (rd !== core_fn(ea[1] ? P_B : P_A) || re !== 1'b0) begin errors++; $display("FAIL simul_data: got %h/%b expected %h/0", rd, re, core_fn(ea[1] ? P_B : P_A)); end
                do_ack(rv);
                m_last = ea[1];
            end
            vectors++; if (rd !== C_B) begin errors++; $display("FAIL simul_second_data: got %h expected %h", rd, C_B); end
        end
    endtask

    task automatic test_timeout();
        logic [1:0] acc, rv; logic [0:127] rd, d; logic re; int ac, vc, ex;
        core_mute = 1'b1;
        bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (vc !== ac + 2 + int'(TMO)) begin errors++; $display("FAIL tmo_latency: got cycle %0d expected %0d", vc, ac + 2 + int'(TMO)); end
        vectors++; if (rv !== 2'b01 || rd !== 128'h0 || re !== 1'b1) begin errors++; $display("FAIL tmo_rsp: got %b %h %b expected 01 0 1", rv, rd, re); end
        vectors++; if (bus.timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b expected 1", bus.timeout_flag); end
        do_ack(2'b01);
        m_last = 1'b0;
        vectors++; if (bus.timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", bus.timeout_flag); end
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        vectors++; if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", bus.timeout_flag); end
        core_mute = 1'b0;
        core_lat  = 3;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req1_data = d;
        bus.req_valid = 2'b10;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (acc !== 2'b10 || rd !== core_fn(d) || re !== 1'b0) begin errors++; $display("FAIL tmo_recover: got %b %h %b expected 10 %h 0", acc, rd, re, core_fn(d)); end
        do_ack(2'b10);
        m_last = 1'b1;
        // clr_err held across the timeout edge: the set must win, then clear next edge
        core_mute = 1'b1;
        bus.clr_err = 1'b1;
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (bus.timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b expected 1", bus.timeout_flag); end
        tick();
        vectors++; if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL tmo_clear_held: got %b expected 0", bus.timeout_flag); end
        bus.clr_err = 1'b0;
        core_mute = 1'b0;
        do_ack(2'b01);
        m_last = 1'b0;
    endtask

    task automatic test_stray();
        logic [1:0] acc, rv; logic [0:127] rd, d; logic re; int ac, vc, ex;
        bus.core_complete = 1'b1;
        tick();
        #1;
        vectors++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.core_ready !== 1'b0) begin errors++; $display("FAIL stray_idle: got busy=%b valid=%b ready=%b expected 0/00/0", bus.busy, bus.rsp_valid, bus.core_ready); end
        core_lat = 4;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req0_data = d;
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        bus.rsp_ack = 2'b10;
        bus.core_complete = 1'b1;
        bus.core_data_out = ~core_fn(d);
        tick();
        bus.rsp_ack = 2'b00;
        vectors++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL stray_wrong_ack: got %b expected 01", bus.rsp_valid); end
        vectors++; if (bus.rsp_data !== core_fn(d)) begin errors++; $display("FAIL stray_respond_complete: got %h expected %h", bus.rsp_data, core_fn(d)); end
        do_ack(2'b01);
        m_last = 1'b0;
        // complete in the very cycle the watchdog expires
        core_lat = int'(TMO);
        bus.req0_data = d;
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (vc !== ac + 2 + int'(TMO) || rd !== core_fn(d) || re !== 1'b0) begin errors++; $display("FAIL edge_complete: got cyc=%0d %h %b expected cyc=%0d %h 0", vc, rd, re, ac + 2 + int'(TMO), core_fn(d)); end
        vectors++; if (bus.timeout_flag !== 1'b0) begin errors++; $display("FAIL edge_flag: got %b expected 0", bus.timeout_flag); end
        do_ack(2'b01);
        // one cycle too late: timeout, and the complete lands in RESPOND
        core_lat = int'(TMO) + 1;
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        tick();
        vectors++; if (bus.rsp_data !== 128'h0 || bus.rsp_err !== 1'b1 || bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL late_complete: got %h %b %b expected 0 1 01", bus.rsp_data, bus.rsp_err, bus.rsp_valid); end
        do_ack(2'b01);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0] acc, rv, ea; logic [0:127] rd; logic re; int ac, vc, ex; bit seen;
        core_lat = 10;
        bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req_valid = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            if (bus.req_accept !== 2'b00) seen = 1'b1;
            tick();
        end
        vectors++; if (!seen) begin errors++; $display("FAIL midrst_accept: got none expected 01 within 10 cycles"); end
        bus.req_valid = 2'b00;
        tick();
        tick();
        #2 n_rst = 1'b0;
        #1;
        vectors++; if ({bus.busy, bus.core_ready, bus.rsp_valid, bus.req_accept, bus.rsp_err, bus.timeout_flag} !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got %b expected 00000000", {bus.busy, bus.core_ready, bus.rsp_valid, bus.req_accept, bus.rsp_err, bus.timeout_flag}); end
        vectors++; if (bus.core_data_in !== 128'h0 || bus.rsp_data !== 128'h0) begin errors++; $display("FAIL midrst_data: got %h/%h expected 0/0", bus.core_data_in, bus.rsp_data); end
        tick();
        n_rst  = 1'b1;
        m_last = 1'b1;
        for (int i = 0; i < 20 && pend; i++) tick();
        tick();
        vectors++; if (pend || bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_late_complete: got pend=%b busy=%b valid=%b expected 0/0/00", pend, bus.busy, bus.rsp_valid); end
        core_lat = 2;
        bus.req0_data = P_A;
        bus.req1_data = P_B;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            ea = ref_grant(bus.req_valid, m_last);
            serve_one(acc, ac, rv, rd, re, vc, ex);
            vectors++; if (acc !== ea || rd !== core_fn(ea[1] ? P_B : P_A)) begin errors++; $display("FAIL midrst_regrant: got %b %h expected %b %h", acc, rd, ea, core_fn(ea[1] ? P_B : P_A)); end
            do_ack(rv);
            m_last = ea[1];
        end
    endtask

    task automatic test_held_response();
        logic [1:0] acc, rv; logic [0:127] rd, d; logic re; int ac, vc, ex, ack_cyc, bad;
        core_lat = 2;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req0_data = d;
        bus.req_valid = 2'b01;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        m_last = 1'b0;
        bus.req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.req_valid = 2'b10;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            vectors++;
            if (bus.rsp_data !== core_fn(d) || bus.req_accept !== 2'b00 || bus.rsp_valid !== 2'b01) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL held_rsp: got %h acc=%b valid=%b expected %h acc=00 valid=01", bus.rsp_data, bus.req_accept, bus.rsp_valid, core_fn(d));
            end
        end
        do_ack(2'b01);
        ack_cyc = cyc;
        serve_one(acc, ac, rv, rd, re, vc, ex);
        vectors++; if (acc !== 2'b10 || ac !== ack_cyc) begin errors++; $display("FAIL held_next_grant: got %b at %0d expected 10 at %0d", acc, ac, ack_cyc); end
        do_ack(rv);
        m_last = 1'b1;
    endtask

    task automatic test_random();
        logic [1:0] acc, rv, ea; logic [0:127] rd, ed; logic re; int ac, vc, ex, lat;
        for (int it = 0; it < 60; it++) begin
            if (!bus.req_valid[0] && $urandom_range(0, 1) == 1) begin
                bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.req_valid[0] = 1'b1;
            end
            if (!bus.req_valid[1] && $urandom_range(0, 1) == 1) begin
                bus.req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.req_valid[1] = 1'b1;
            end
            if (bus.req_valid == 2'b00) begin
                bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.req_valid[0] = 1'b1;
            end
            ea  = ref_grant(bus.req_valid, m_last);
            ed  = core_fn(ea[1] ? bus.req1_data : bus.req0_data);
            lat = int'($urandom_range(1, 20));
            core_lat = lat;
            serve_one(acc, ac, rv, rd, re, vc, ex);
            vectors++; if (acc !== ea || rv !== ea || ex !== 0) begin errors++; $display("FAIL rand_grant[%0d]: got acc=%b valid=%b extra=%0d expected %b/%b/0", it, acc, rv, ex, ea, ea); end
            vectors++; if (rd !== ed || re !== 1'b0) begin errors++; $display("FAIL rand_data[%0d]: got %h/%b expected %h/0", it, rd, re, ed); end
            vectors++; if (vc !== ac + 2 + lat) begin errors++; $display("FAIL rand_latency[%0d]: got cycle %0d expected %0d", it, vc, ac + 2 + lat); end
            repeat ($urandom_range(0, 3)) begin
                bus.rsp_ack = ~ea;
                tick();
                bus.rsp_ack = 2'b00;
            end
            vectors++; if (bus.rsp_valid !== ea) begin errors++; $display("FAIL rand_hold[%0d]: got %b expected %b", it, bus.rsp_valid, ea); end
            do_ack(ea);
            m_last = ea[1];
        end
        bus.req_valid = 2'b00;
    endtask

    initial begin
        n_rst             = 1'b1;
        bus.req_valid     = '0;
        bus.req0_data     = '0;
        bus.req1_data     = '0;
        bus.rsp_ack       = '0;
        bus.clr_err       = 1'b0;
        bus.core_complete = 1'b0;
        bus.core_data_out = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_stray();
        test_reset_mid_wait();
        test_held_response();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one aes_control encryption core between two requesters: req0 is the USB OUT-data path and req1 is the self-test / key-check path.
- Round-robin arbitration; one block outstanding in the core at a time.
- Issues the core's single-cycle ready pulse, waits for complete, and returns the 128-bit result to the granted requester through a valid/ack handshake.
- A watchdog flags a core that never completes.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in WAIT before a timeout is declared. Legal range 2..255.
- CNT_W, 8: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester block-request strobe; held high until the matching req_accept bit.
- req0_data  in  128 [0:127]  requester 0 plaintext block; stable while req_valid[0]=1.
- req1_data  in  128 [0:127]  requester 1 plaintext block; stable while req_valid[1]=1.
- req_accept  out  2  one-hot, one-cycle, combinational; data is captured on the edge ending this cycle.
- rsp_valid  out  2  one-hot, registered; result available for the granted requester.
- rsp_data  out  128 [0:127]  result block, shared by both requesters; qualified by rsp_valid.
- rsp_err  out  1  high with rsp_valid when the result is a timeout (rsp_data = 0).
- rsp_ack  in  2  per-requester result acknowledge; only the bit matching rsp_valid is honoured.
- core_ready  out  1  to aes_control.ready; one-cycle start pulse.
- core_data_in  out  128 [0:127]  to aes_control.data_in; latched block.
- core_complete  in  1  from aes_control.complete.
- core_data_out  in  128 [0:127]  from aes_control.data_out; valid in the core_complete cycle.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky timeout indicator; cleared by clr_err.
- clr_err  in  1  synchronous clear of timeout_flag.

Behaviour:
- Reset (n_rst=0, async):
  - state=IDLE, last_grant=1 so requester 0 wins the first tie.
  - Outputs: req_accept=0, rsp_valid=0, rsp_err=0, rsp_data=0, core_ready=0, core_data_in=0, busy=0, timeout_flag=0, watchdog=0.
- Reset mid-operation: all state is discarded. Any later core_complete from the abandoned block arrives in IDLE and is ignored.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - Grant rule: if exactly one req_valid bit is set, grant it. If both are set, grant the requester that is not last_grant.
  - Grant cycle: req_accept[g]=1; on that edge latch the block into core_data_in, record g, and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - core_ready=1 for exactly this one cycle; watchdog cleared to 0.
  - Always goes to WAIT next.
- WAIT:
  - core_ready=0; the watchdog increments every cycle.
  - core_complete=1: capture core_data_out into rsp_data, rsp_err=0, go to RESPOND.
  - Watchdog reaches TIMEOUT_CYCLES-1 without complete: rsp_data=0, rsp_err=1, set timeout_flag, go to RESPOND.
  - complete and timeout in the same cycle: complete wins, no error.
- RESPOND:
  - rsp_valid[g]=1; rsp_data and rsp_err are held stable.
  - rsp_ack[g]=1: on that edge clear rsp_valid, set last_grant=g, return to IDLE.
  - rsp_ack on the non-granted bit is ignored.
  - New requests are not accepted in this state; req_accept=0.
- core_complete seen outside WAIT is ignored.
- Latency: req_valid sampled in IDLE cycle T.
  - Accept in cycle T; core_ready in T+1; WAIT from T+2.
  - If core_complete arrives in cycle C, rsp_valid is high from C+1.
  - Minimum request-to-rsp_valid is 3 cycles when complete arrives in T+2.
  - Back-to-back throughput: the next grant is possible in the cycle after ack.
- clr_err: clears timeout_flag on the next edge. If a timeout is declared in the same cycle, set wins.
- busy = (state != IDLE), registered.
- No combinational path from core inputs to core outputs. req_accept depends only on state, req_valid and last_grant.

Test Plan:
- Single request: reset; req_valid=01, req0_data=61646a6163656e746163746976617465; core returns complete 10 cycles after core_ready -> req_accept=01 for 1 cycle; core_ready high for exactly 1 cycle; rsp_valid=01 with rsp_data=b1e9645c3fc771108b4ce598d2896ee5 and rsp_err=0; cleared by rsp_ack=01.
- Simultaneous requests: req_valid=11 held, req0_data=616172647661726b616172647661726b, req1_data=626564736f7265736265646672616d65 -> grant order 0 then 1; the second rsp_data is 36b8bd11fb127be91568ba69c370cbe5. Repeat with both valid again -> grant order continues 0,1,0,1.
- Timeout: core model never asserts complete, TIMEOUT_CYCLES=64 -> rsp_valid high exactly 64 cycles after entry to WAIT; rsp_err=1, rsp_data=0, timeout_flag=1. clr_err=1 clears timeout_flag; a later normal block completes with rsp_err=0.
- Stray and late events:
  - core_complete pulsed in IDLE and RESPOND -> no state change.
  - rsp_ack=10 while rsp_valid=01 -> rsp_valid stays at 01.
  - Complete on the same cycle the watchdog hits TIMEOUT_CYCLES-1 -> rsp_err=0 and the data is captured.
- Reset mid-WAIT: assert n_rst=0 asynchronously between clock edges while in WAIT -> all outputs go to 0 immediately. After release, a late core_complete is ignored; the next request from requester 0 is granted first.
- Held response: keep rsp_ack=0 for 20 cycles with req_valid=10 pending -> rsp_data stable, req_accept=00 throughout; req1 is accepted in the cycle after the ack.
